// File: rtl/switch_reader_if.sv
// switch_reader_if: raw switch inputs and debounced outputs of switch_reader.
// IRQ pins exist only when SWITCH_READER_IRQ_EN is defined.
interface switch_reader_if #(parameter int WIDTH = 8);
    logic [WIDTH-1:0] sw_in;
    logic [WIDTH-1:0] sw;
    logic [WIDTH-1:0] sw_rise;
    logic [WIDTH-1:0] sw_fall;
    logic [15:0] event_count;
`ifdef SWITCH_READER_IRQ_EN
    logic irq_clr;
    logic irq;
    modport master(output sw_in, irq_clr, input sw, sw_rise, sw_fall, event_count, irq);
    modport slave(input sw_in, irq_clr, output sw, sw_rise, sw_fall, event_count, irq);
`else
    modport master(output sw_in, input sw, sw_rise, sw_fall, event_count);
    modport slave(input sw_in, output sw, sw_rise, sw_fall, event_count);
`endif
endinterface

// File: rtl/switch_reader.sv
// switch_reader: synchronise, debounce and edge-detect WIDTH switch lines, counting rises.
// Define SWITCH_READER_IRQ_EN to add a sticky IRQ with IRQ_CLR.
module switch_reader #(
    parameter int WIDTH = 8,
    parameter int unsigned STABLE_CYCLES = 1023,
    parameter int SYNC_STAGES = 2
) (
    input logic CLK,
    input logic RST,
    switch_reader_if.slave bus
);
    localparam logic [31:0] LAST = 32'(STABLE_CYCLES - 1);
    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
    logic [31:0] cnt_q [WIDTH];
    logic [31:0] cnt_d [WIDTH];
    logic [WIDTH-1:0] sync, sw_q, sw_d, rise_q, rise_d, fall_q, fall_d;
    logic [15:0] event_count_q, event_count_d;
    assign sync = sync_q[SYNC_STAGES-1];
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], bus.sw_in};
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = (sync[i] == sw_q[i] || cnt_q[i] == LAST) ? '0 : cnt_q[i] + 32'd1;
            sw_d[i] = (sync[i] != sw_q[i] && cnt_q[i] == LAST) ? sync[i] : sw_q[i];
            rise_d[i] = sw_d[i] & ~sw_q[i];
            fall_d[i] = ~sw_d[i] & sw_q[i];
        end
        // count moves on the same edge the rise pulses are registered
        event_count_d = event_count_q + 16'($countones(rise_d));
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_q <= '0;
            cnt_q <= '{default: '0};
            sw_q <= '0;
            rise_q <= '0;
            fall_q <= '0;
            event_count_q <= '0;
        end else begin
            sync_q <= sync_d;
            cnt_q <= cnt_d;
            sw_q <= sw_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            event_count_q <= event_count_d;
        end
    end
    assign bus.sw = sw_q;
    assign bus.sw_rise = rise_q;
    assign bus.sw_fall = fall_q;
    assign bus.event_count = event_count_q;
`ifdef SWITCH_READER_IRQ_EN
    logic irq_q, irq_d;
    // a pulse seen this cycle beats a simultaneous clear
    always_comb irq_d = |(rise_q | fall_q) || (irq_q && !bus.irq_clr);
    always_ff @(posedge CLK) irq_q <= RST ? 1'b0 : irq_d;
    assign bus.irq = irq_q;
`endif
endmodule

// File: tb/tb_switch_reader.sv
// tb_switch_reader: randomized and directed stimulus; a reference model queues expected
// pulse events that a monitor pops and compares whenever the DUT pulses.
`timescale 1ns/1ps
module tb_switch_reader;
    localparam int W = 8;
    localparam int SC = 16;
    localparam int SS = 2;

    typedef struct {
        int edge_n;
        logic [W-1:0] rise;
        logic [W-1:0] fall;
        logic [W-1:0] sw;
        logic [15:0] cnt;
    } ev_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    switch_reader_if #(.WIDTH(W)) bus();
    switch_reader #(.WIDTH(W), .STABLE_CYCLES(SC), .SYNC_STAGES(SS)) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    ev_t exp_q[$];
    int cyc = 0;
    int checks = 0;
    int fails = 0;

    // model state: delay line, debounced level and start edge of the current mismatch streak
    logic [W-1:0] pipe [SS];
    logic [W-1:0] deb = '0;
    int since [W];
    logic [15:0] cnt_m = '0;
    logic irq_m = 1'b0;
    logic [W-1:0] last_pulse = '0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at edge %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    always @(posedge CLK) begin : model
        logic [W-1:0] s, r, f;
        cyc++;
        if (RST) begin
            for (int k = 0; k < SS; k++) pipe[k] = '0;
            for (int i = 0; i < W; i++) since[i] = -1;
            deb = '0;
            cnt_m = '0;
            irq_m = 1'b0;
            last_pulse = '0;
        end else begin
            s = pipe[SS-1];
            r = '0;
            f = '0;
            for (int i = 0; i < W; i++) begin
                if (s[i] == deb[i]) since[i] = -1;
                else begin
                    if (since[i] < 0) since[i] = cyc;
                    if (cyc - since[i] + 1 == SC) begin
                        deb[i] = s[i];
                        r[i] = s[i];
                        f[i] = !s[i];
                        since[i] = -1;
                    end
                end
            end
            cnt_m = cnt_m + 16'($countones(r));
`ifdef SWITCH_READER_IRQ_EN
            irq_m = (|last_pulse) ? 1'b1 : bus.irq_clr ? 1'b0 : irq_m;
`endif
            last_pulse = r | f;
            if (|(r | f)) exp_q.push_back('{cyc, r, f, deb, cnt_m});
            for (int k = SS - 1; k > 0; k--) pipe[k] = pipe[k-1];
            pipe[0] = bus.sw_in;
        end
    end

    always @(negedge CLK) begin : monitor
        ev_t e;
        if (cyc > 0) begin
            check("sw_level", bus.sw, deb);
            check("event_count", bus.event_count, cnt_m);
`ifdef SWITCH_READER_IRQ_EN
            check("irq", bus.irq, irq_m);
`endif
            if (|(bus.sw_rise | bus.sw_fall)) begin
                if (exp_q.size() == 0) check("unexpected_pulse", {bus.sw_rise, bus.sw_fall}, 0);
                else begin
                    e = exp_q.pop_front();
                    check("pulse_edge", cyc, e.edge_n);
                    check("sw_rise", bus.sw_rise, e.rise);
                    check("sw_fall", bus.sw_fall, e.fall);
                    check("pulse_sw", bus.sw, e.sw);
                    check("pulse_count", bus.event_count, e.cnt);
                end
            end else if (exp_q.size() > 0 && exp_q[0].edge_n <= cyc) begin
                e = exp_q.pop_front();
                check("missed_pulse", {bus.sw_rise, bus.sw_fall}, {e.rise, e.fall});
            end
        end
    end

    task automatic hold(logic [W-1:0] v, int n);
        bus.sw_in = v;
        repeat (n) @(negedge CLK);
    endtask

    initial begin
        logic [W-1:0] v;
        bus.sw_in = 8'hA5;
`ifdef SWITCH_READER_IRQ_EN
        bus.irq_clr = 1'b0;
`endif
        repeat (5) begin
            @(negedge CLK);
            check("rst_sw", bus.sw, 0);
            check("rst_pulses", {bus.sw_rise, bus.sw_fall}, 0);
            check("rst_count", bus.event_count, 0);
        end
        RST = 1'b0;
        hold(8'hA5, 25);
        check("powerup_sw", bus.sw, 8'hA5);
        check("powerup_count", bus.event_count, 4);
        hold(8'h00, 25);
        hold(8'h01, 25);
        hold(8'h00, 25);
        hold(8'h02, 15);
        hold(8'h00, 25);
        check("glitch15_sw", bus.sw, 0);
        hold(8'h02, 16);
        hold(8'h00, 25);
        for (int t = 0; t < 8; t++) hold(t[0] ? 8'h00 : 8'h04, 5);
        hold(8'h04, 25);
        check("bounce_sw", bus.sw, 8'h04);
        hold(8'hFF, 25);
        hold(8'h00, 25);
        hold(8'hFF, 25);
        hold(8'h00, 25);
        bus.sw_in = 8'h08;
        repeat (12) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        check("midsettle_rst_sw", bus.sw, 0);
        RST = 1'b0;
        hold(8'h08, 25);
        check("after_rst_sw", bus.sw, 8'h08);
        v = 8'h08;
        repeat (250) begin
            v = v ^ 8'($urandom & $urandom);
`ifdef SWITCH_READER_IRQ_EN
            bus.irq_clr = 1'($urandom_range(0, 1));
`endif
            hold(v, $urandom_range(1, 40));
        end
        hold(v, 30);
        check("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/switch_reader.md
Name: switch_reader

Overview:
- Input-side GPIO block: samples WIDTH asynchronous switch/button lines and synchronises them to CLK.
- Debounces each line independently.
- Reports the debounced level, one-cycle rise/fall pulses and a running count of rising events.
- Sits at board-level inputs in the LED demo designs, feeding control logic, just as the LED driver sits at board-level outputs.

Parameters:
- WIDTH, 8, number of switch lines.
- STABLE_CYCLES, 1023, consecutive cycles a synchronised line must differ from its debounced value before the debounced value updates; legal range 1..2^32-1.
- SYNC_STAGES, 2, synchroniser flop depth per line; legal range 2..4.

Ports:
- CLK  input  1  clock.
- RST  input  1  reset, synchronous, active-high.
- SW_IN  input  WIDTH  raw asynchronous switch levels.
- SW  output  WIDTH  debounced levels (registered).
- SW_RISE  output  WIDTH  per-line one-cycle pulse on debounced 0->1.
- SW_FALL  output  WIDTH  per-line one-cycle pulse on debounced 1->0.
- EVENT_COUNT  output  16  total debounced rising edges, all lines, modulo 2^16.

Behaviour:
- Reset (RST=1 at a CLK edge) clears the following to 0:
  - all synchroniser flops;
  - all per-line counters;
  - SW, SW_RISE, SW_FALL and EVENT_COUNT.
- Reset mid-settle discards partial counts.
- Synchroniser: SYNC_STAGES-deep flop chain per line. The last stage is sync[i].
- Per-line counter cnt[i]: 32 bits, unsigned. Each edge when not in reset:
  - sync[i]==SW[i]: cnt[i]<=0; SW_RISE[i]<=0; SW_FALL[i]<=0.
  - sync[i]!=SW[i] and cnt[i]==STABLE_CYCLES-1: SW[i]<=sync[i]; cnt[i]<=0; SW_RISE[i]<=sync[i]; SW_FALL[i]<=!sync[i].
  - otherwise: cnt[i]<=cnt[i]+1; pulses 0.
- Latency:
  - SW_IN changes before edge k and is held. SW changes, and the matching pulse asserts, at edge k+SYNC_STAGES+STABLE_CYCLES-1.
  - Defaults: 1024 edges after the first sampling edge.
- Glitch rejection: a mismatch lasting fewer than STABLE_CYCLES synchronised cycles returns cnt[i] to 0; SW[i] stays unchanged and no pulse fires.
- Pulses:
  - exactly one cycle wide;
  - registered, so they assert on the same edge SW updates;
  - a line never asserts RISE and FALL together.
  - A pulse is never asserted in consecutive cycles on the same line, since the counter restarts.
- EVENT_COUNT:
  - on each edge, adds popcount of the SW_RISE value being registered that edge, so the count and the pulses update together;
  - simultaneous rises on n lines add n;
  - wraps 65535 -> 0 without saturation;
  - falls do not count.
- Lines are fully independent; simultaneous transitions on several lines are handled in parallel.
- Power-up with switch held high: after reset release, SW rises after the latency above and produces a RISE pulse and a count. This is intended.

Optional Feature:
- Macro SWITCH_READER_IRQ_EN.
- Defined:
  - Adds input IRQ_CLR (1 bit) and output IRQ (1 bit, registered, reset 0).
  - IRQ is set on the edge after any SW_RISE or SW_FALL bit is 1.
  - IRQ clears on the edge IRQ_CLR=1.
  - If set and clear occur on the same edge, set wins.
  - IRQ stays high until cleared.
- Undefined: neither port exists; all other behaviour is identical.

Test Plan (WIDTH=8, STABLE_CYCLES=16, SYNC_STAGES=2):
1. Hold RST=1 for 5 cycles with SW_IN=8'hA5, then release -> during reset SW=0, pulses=0, EVENT_COUNT=0. 17 edges after release, SW=8'hA5, SW_RISE=8'hA5 for one cycle, EVENT_COUNT=4.
2. From SW=0, set SW_IN=8'h01 and hold -> SW[0]=1 exactly 17 edges later; SW_RISE=8'h01 one cycle; EVENT_COUNT +1. Then SW_IN=0 -> SW_FALL=8'h01 after 17 edges; EVENT_COUNT unchanged.
3. Glitch: SW_IN[1]=1 for 15 cycles, then 0 -> SW stays 0, no pulses, EVENT_COUNT unchanged. Repeat with 16 cycles -> SW[1] rises at the 17th edge, then falls 17 edges after release.
4. Bounce: toggle SW_IN[2] every 5 cycles for 40 cycles, then hold 1 -> exactly one SW_RISE[2], 17 edges after the final transition.
5. SW=8'hFF, then SW_IN=8'h00 -> SW_FALL=8'hFF in one cycle. Back to 8'hFF -> SW_RISE=8'hFF; EVENT_COUNT +8.
6. Assert RST at cnt=10 mid-settle -> all cleared. With SW_IN still 1, the rise reappears 17 edges after release. With SWITCH_READER_IRQ_EN defined, IRQ rises the edge after the pulse. If IRQ_CLR is asserted on the same edge as a new pulse, IRQ stays 1.
